// File: rtl/settings_pkg.sv
// Shared sizing for the convolution datapath plus result-sink defaults and types.
package settings_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned FULL_SIZE  = 36;

  localparam int unsigned SINK_DEPTH = 16;
  localparam int unsigned SINK_SHIFT = 15;

  typedef logic signed [DATA_SIZE-1:0] sink_data_t;
  typedef logic signed [FULL_SIZE-1:0] full_data_t;

endpackage

// File: rtl/convol_result_intf.sv
// Convolution result stream: core drives the master side, the sink reads the slave side.
interface convol_result_intf;
  import settings_pkg::*;

  full_data_t output_data;
  logic       output_data_valid;

  modport master (output output_data, output output_data_valid);
  modport slave  (input  output_data, input  output_data_valid);

endinterface

// File: rtl/convol_result_fifo.sv
// Synchronous FIFO with occupancy; extra pointer bit separates full from empty.
module convol_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/convol_result_sink.sv
// Result sink: scale register, FIFO, overflow flag and accepted-sample counter.
// Define CONVOL_SINK_SAT_EN to saturate instead of wrap when narrowing.
module convol_result_sink
  import settings_pkg::*;
#(
  parameter int unsigned DEPTH    = SINK_DEPTH,
  parameter int unsigned SHIFT    = SINK_SHIFT,
  parameter int unsigned CNT_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  full_data_t              output_data,
  input  logic                    output_data_valid,
  output sink_data_t              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_SIZE-1:0]     sample_count
);

  convol_result_intf res_if ();
  assign res_if.output_data       = output_data;
  assign res_if.output_data_valid = output_data_valid;

  sink_data_t          scaled_d, scaled_q;
  logic                scaled_valid_q;
  logic                overflow_q;
  logic [CNT_SIZE-1:0] count_q;
  logic                fifo_empty, fifo_full;
  logic                push, pop, drop;

`ifdef CONVOL_SINK_SAT_EN
  localparam full_data_t SAT_MAX = full_data_t'((longint'(1) << (DATA_SIZE-1)) - 1);
  localparam full_data_t SAT_MIN = ~SAT_MAX;
  full_data_t shifted;

  always_comb begin
    shifted = res_if.output_data >>> SHIFT;
    if (shifted > SAT_MAX)      scaled_d = sink_data_t'(SAT_MAX);
    else if (shifted < SAT_MIN) scaled_d = sink_data_t'(SAT_MIN);
    else                        scaled_d = sink_data_t'(shifted);
  end
`else
  always_comb begin
    scaled_d = sink_data_t'(res_if.output_data >>> SHIFT);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scaled_q       <= '0;
      scaled_valid_q <= 1'b0;
    end else if (clear) begin
      scaled_valid_q <= 1'b0;
    end else begin
      scaled_valid_q <= res_if.output_data_valid;
      if (res_if.output_data_valid) scaled_q <= scaled_d;
    end
  end

  assign pop  = m_valid && m_ready;
  assign push = scaled_valid_q && (!fifo_full || pop);
  assign drop = scaled_valid_q && !push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else if (clear) begin
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (push) count_q    <= count_q + CNT_SIZE'(1);
    end
  end

  convol_result_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (scaled_q),
    .pop   (pop),
    .rdata (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign m_valid      = !fifo_empty;
  assign overflow     = overflow_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_convol_result_sink.sv
// Randomised scoreboard bench for convol_result_sink against a queue-level reference.
module tb_convol_result_sink;
  import settings_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SHIFT = 15;
  localparam int unsigned CNT   = 32;

  logic                   clk = 1'b0;
  logic                   reset, clear, vin, m_ready;
  logic [FULL_SIZE-1:0]   din;
  logic [DATA_SIZE-1:0]   m_data;
  logic                   m_valid, overflow;
  logic [$clog2(DEPTH):0] level;
  logic [CNT-1:0]         sample_count;

  int vectors = 0;
  int errors  = 0;

  // Reference: FIFO contents, expected output order, pending scaled sample.
  logic [DATA_SIZE-1:0] mq[$];
  logic [DATA_SIZE-1:0] exp_q[$];
  bit                   s1v;
  logic [DATA_SIZE-1:0] s1d;
  bit                   movf;
  longint               mcnt;

  bit                   prev_stall;
  logic [DATA_SIZE-1:0] prev_data;

  convol_result_sink #(
    .DEPTH    (DEPTH),
    .SHIFT    (SHIFT),
    .CNT_SIZE (CNT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .clear             (clear),
    .output_data       (din),
    .output_data_valid (vin),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .level             (level),
    .overflow          (overflow),
    .sample_count      (sample_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_SIZE-1:0] ref_scale(input logic [FULL_SIZE-1:0] d);
    longint v, div, q, hi, lo;
    v   = longint'($signed(d));
    div = longint'(1) << SHIFT;
    q   = v / div;
    if (v < 0 && (v % div) != 0) q = q - 1;
    hi  = (longint'(1) << (DATA_SIZE-1)) - 1;
    lo  = -hi - 1;
`ifdef CONVOL_SINK_SAT_EN
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`endif
    return q[DATA_SIZE-1:0];
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    s1v  = 1'b0;
    s1d  = '0;
    movf = 1'b0;
    mcnt = 0;
  endfunction

  function automatic void model_edge();
    bit rd, wr;
    if (clear) begin
      model_reset();
      return;
    end
    rd = (mq.size() != 0) && m_ready;
    wr = s1v && (mq.size() < DEPTH || rd);
    if (s1v && !wr) movf = 1'b1;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      mq.push_back(s1d);
      exp_q.push_back(s1d);
      mcnt++;
    end
    s1v = vin;
    if (vin) s1d = ref_scale(din);
  endfunction

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_edge();
  end

  // Monitor: state checks, stall stability and in-order scoreboard on handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("level", level, mq.size());
      chk("m_valid", m_valid, mq.size() != 0);
      chk("overflow", overflow, movf);
      chk("sample_count", sample_count, mcnt % (longint'(1) << CNT));
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else                   chk("sb_data", m_data, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready && !clear;
      prev_data  = m_data;
    end
  end

  task automatic step(input bit v, input logic [FULL_SIZE-1:0] d, input bit r, input bit c);
    vin = v; din = d; m_ready = r; clear = c;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (mq.size() != 0 || s1v); i++) step(0, '0, 1, 0);
    chk("drain_level", level, 0);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1, FULL_SIZE'(longint'(base + i) << SHIFT), 0, 0);
  endtask

  initial begin
    logic [63:0]          r64;
    logic [FULL_SIZE-1:0] big;
    int                   issued, cyc;

    reset = 1'b1; clear = 1'b0; vin = 1'b0; m_ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", sample_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Latency and floor rounding.
    step(1, 36'h0_0000_8000, 1, 0);
    chk("lat_n1_valid", m_valid, 0);
    step(0, '0, 1, 0);
    chk("lat_n2_valid", m_valid, 1);
    chk("scale_one", m_data, 16'h0001);
    step(1, -36'sd32768, 1, 0);
    step(0, '0, 1, 0);
    chk("neg_floor", m_data, 16'hFFFF);

    big = 36'h4_0000_0000;
    step(1, big, 1, 0);
    step(0, '0, 1, 0);
`ifdef CONVOL_SINK_SAT_EN
    chk("pos_big", m_data, 16'h7FFF);
`else
    chk("pos_big", m_data, 16'h0000);
`endif
    big = -big;
    step(1, big, 1, 0);
    step(0, '0, 1, 0);
`ifdef CONVOL_SINK_SAT_EN
    chk("neg_big", m_data, 16'h8000);
`else
    chk("neg_big", m_data, 16'h0000);
`endif
    drain();

    // Continuous stream with ready held high.
    for (int i = 0; i < 24; i++) step(1, FULL_SIZE'(longint'(i) << SHIFT), 1, 0);
    chk("stream_level", level, 1);
    chk("stream_ovf", overflow, 0);
    drain();

    // Fill past capacity, then drain 1..16.
    step(0, '0, 0, 1);
    fill(17, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("fill_level", level, 16);
    chk("fill_ovf", overflow, 1);
    chk("fill_count", sample_count, 16);
    drain();

    // Full FIFO with a write landing on a read.
    step(0, '0, 0, 1);
    fill(16, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(1, FULL_SIZE'(longint'(100) << SHIFT), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    chk("full_rw_level", level, 16);
    chk("full_rw_ovf", overflow, 0);
    chk("full_rw_count", sample_count, 17);
    drain();

    // Randomised backpressure.
    step(0, '0, 0, 1);
    issued = 0;
    cyc    = 0;
    while (issued < 1000 && cyc < 20000) begin
      bit v, r;
      v   = ($urandom_range(2) == 0);
      r   = ($urandom_range(2) != 0);
      r64 = {$urandom, $urandom};
      step(v, r64[FULL_SIZE-1:0], r, 0);
      if (v) issued++;
      cyc++;
    end
    chk("rand_issued", issued, 1000);
    drain();
    chk("rand_count", sample_count, 1000);
    chk("rand_sb_empty", exp_q.size(), 0);

    // Clear mid-stream with overflow set and a sample in flight.
    step(0, '0, 0, 1);
    fill(17, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, '0, 1, 0);
    step(1, FULL_SIZE'(longint'(7) << SHIFT), 0, 0);
    chk("pre_clear_level", level, 5);
    step(1, FULL_SIZE'(longint'(9) << SHIFT), 0, 1);
    chk("clr_level", level, 0);
    chk("clr_valid", m_valid, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_count", sample_count, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("clr_killed_level", level, 0);

    // Asynchronous reset between edges.
    fill(3, 40);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("pre_rst_level", level, 3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_level", level, 0);
    chk("arst_count", sample_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, FULL_SIZE'(longint'(5) << SHIFT), 0, 0);
    step(0, '0, 0, 0);
    chk("post_rst_data", m_data, 5);
    drain();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
